uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that sits directly downstream of the UART character buffer. It accepts one byte per `send` pulse and shifts it out on `tx` as an asynchronous 8N1 frame: start bit, 8 data bits LSB first, optional parity, one stop bit. It drives `ready` back to the buffer so that exactly one byte is popped per frame. Its `tx` output goes to the board UART pin.

## Interface
- `CLK_FREQ`, 100_000_000: `clk` frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (integer division, truncates): clock cycles per bit. Legal range is 2 and up; a value below 2 is an elaboration error.

Ports:
- `clk`  in  1  the single clock. All state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `send`  in  1  one-cycle strobe. `data` is valid in the same cycle.
- `data`  in  8  byte to transmit.
- `ready`  out  1  combinational: `(state == IDLE) && !send`.
- `tx`  out  1  serial line, registered. Idles high.
- `done`  out  1  registered, one-cycle pulse when a frame's stop bit ends.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Registers:
  - `state`.
  - `baud_cnt`, width clog2(`CLKS_PER_BIT`), counts 0..`CLKS_PER_BIT`-1.
  - `bit_idx`, 3 bits.
  - `shreg`, 8 bits.
  - `par`, 1 bit.
  - `tx`, `done`.
- IDLE:
  - `tx`=1.
  - On `send`=1: `shreg`<=`data`, `par`<=^`data`, `baud_cnt`<=0, go to START.
- START:
  - `tx`=0 for `CLKS_PER_BIT` cycles.
  - Then go to DATA with `bit_idx`=0.
- DATA:
  - `tx`=`shreg[0]` for each bit period.
  - At the end of each period: `shreg`>>=1, `bit_idx`+=1.
  - After `bit_idx`==7 completes: go to PARITY if compiled in, else STOP.
- PARITY: `tx`=`par` for one bit period, then go to STOP.
- STOP:
  - `tx`=1 for one bit period.
  - At the end: `done`=1 for one cycle, go to IDLE.
- `baud_cnt` wraps from `CLKS_PER_BIT`-1 to 0. The wrap marks the end of a bit period.
- `send` outside IDLE: ignored, byte dropped, no state change. The upstream buffer never does this because `ready` is low.
- `send` in the same cycle that STOP completes: ignored, since `ready` was low. The byte is taken on the next IDLE cycle in which `send` is high.
- Reset mid-frame: `tx` goes high immediately (asynchronous), frame aborted, `done` not pulsed.

## Timing
- Reset values: `state`=IDLE, `tx`=1, `done`=0, counters 0. `ready`=1 while `send`=0.
- Acceptance:
  - `send` sampled at edge E.
  - `tx` falls after edge E.
  - `ready` is low from the cycle `send` rises until the cycle after STOP ends.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- `done` is high during the first cycle back in IDLE. `ready` is high in that same cycle.
- Back-to-back frames: the next frame's start bit begins no later than 2 cycles after `done` when upstream data is available (buffer registers `send` one cycle after seeing `ready`).
- Bit-rate error from truncation is not corrected.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state exists and emits one even-parity bit (`^data`) between the data bits and stop. Frame is 8E1, 11 bit periods.
  - Undefined: PARITY state and `par` register are absent. Frame is 8N1, 10 bit periods.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles, release -> `tx`=1, `ready`=1, `done`=0; no activity for 50 cycles.
- Single byte (`CLKS_PER_BIT`=10, no parity): `send` 0x55 -> `tx` = 0,1,0,1,0,1,0,1,0,1, each held 10 cycles. `done` pulses 100 cycles after acceptance; `ready` low throughout the frame.
- Back-to-back via the upstream buffer: push 0x41,0x42,0x0A with `add_cr`=1 -> four frames 0x41,0x42,0x0A,0x0D. Each start bit is at most 2 cycles after the previous `done`; no byte lost or duplicated.
- Ignored send: pulse `send` with 0xFF mid-frame while 0x00 is in flight -> the 0x00 frame is unchanged and no second frame follows.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x00 -> `tx`=1 immediately, no `done`. After release, sending 0xA5 produces a correct frame.
- Parity (macro defined): `send` 0x07 -> parity bit 1; `send` 0x03 -> parity bit 0; frame length 110 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake between the UART character buffer (master) and uart_tx (slave).
interface uart_tx_if;
    logic       send;
    logic [7:0] data;
    logic       ready;
    logic       done;

    modport master (output send, data, input ready, done);
    modport slave  (input send, data, output ready, done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; define UART_TX_PARITY_EN for 8E1 (even parity bit before stop).
// tx and done are registered; ready is combinational so the buffer pops exactly once per frame.
module uart_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx
);
    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          wrap;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign wrap      = (cnt_q == CNT_MAX);
    assign tx        = tx_q;
    assign bus.done  = done_q;
    assign bus.ready = (state_q == IDLE) && !bus.send;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // tx_d carries the level of the upcoming bit so tx changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) cnt_d = wrap ? '0 : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.send) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    sh_d    = bus.data;
                    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^bus.data;
`endif
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    tx_d  = sh_q[1];
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit; a line decoder feeds a byte scoreboard.
module tb_uart_tx;
    localparam int C = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;

    uart_tx_if u_if ();
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rst_cnt = 0;
    int frames = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          start_q[$];
    int          done_cq[$];
    logic [10:0] last_raw;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_cnt <= rst_cnt + 1;
    always @(negedge clk) if (u_if.done === 1'b1) begin
        done_cnt <= done_cnt + 1;
        done_cq.push_back(cyc);
    end

    // Line decoder: samples each bit at its centre, discards frames cut by reset.
    int          m_r0, m_st;
    logic [10:0] m_raw;
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            m_r0  = rst_cnt;
            m_st  = cyc;
            m_raw = '1;
            for (int i = 0; i < NB; i++) begin
                for (int k = 0; k < ((i == 0) ? C / 2 : C); k++)
                    if (rst_cnt == m_r0) @(negedge clk);
                m_raw[i] = tx;
            end
            if (rst_cnt == m_r0) begin
                last_raw = m_raw;
                frames   = frames + 1;
                start_q.push_back(m_st);
                rx_q.push_back(m_raw[8:1]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain_sb();
        logic [7:0] r;
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra_frame: got 0x%02h, expected no frame", r);
            end else begin
                check("sb_data", {24'd0, r}, {24'd0, exp_q.pop_front()});
            end
        end
    endtask

    // Buffer model: sees ready, raises send one cycle later for one cycle.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (u_if.ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, u_if.ready}, 32'd1);
        @(posedge clk); #1;
        u_if.send = 1'b1;
        u_if.data = b;
        exp_q.push_back(b);
        @(posedge clk); #1;
        u_if.send = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (u_if.done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, u_if.done}, 32'd1);
        dcyc = cyc;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int acc, dc, bad, base, gap, f0;
        logic [7:0] b2b[$];
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'hA5, 1'b0};
        vecs[6] = '{8'h3C, 1'b0};
        vecs[7] = '{8'h07, 1'b1};
        u_if.send = 1'b0;
        u_if.data = 8'h00;

        // Reset and idle line
        repeat (5) @(posedge clk);
        #1 check("rst_tx_during", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, u_if.ready}, 32'd1);
        check("rst_done", {31'd0, u_if.done}, 32'd0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || u_if.done !== 1'b0 || u_if.ready !== 1'b1) bad++;
        end
        check("idle_quiet", bad, 0);

        // Single 0x55 frame: exact line pattern, latency, ready low throughout
        send_byte(8'h55, acc);
        bad = 0;
        dc = 0;
        for (int n = 0; n < FRAME + 20; n++) begin
            @(negedge clk);
            if (u_if.done === 1'b1) begin
                dc = cyc;
                break;
            end
            if (u_if.ready !== 1'b0) bad++;
        end
        check("single_ready_low", bad, 0);
        check("single_done_lat", dc - acc, FRAME);
        check("single_ready_at_done", {31'd0, u_if.ready}, 32'd1);
`ifdef UART_TX_PARITY_EN
        check("single_raw", {21'd0, last_raw}, {21'd0, 11'b1_0_01010101_0});
`else
        check("single_raw", {21'd0, last_raw}, {21'd0, 11'b1_1_01010101_0});
`endif
        drain_sb();

        // Table of bytes: framing, parity and latency per byte
        foreach (vecs[i]) begin
            send_byte(vecs[i].data, acc);
            wait_done(dc);
            check("vec_done_lat", dc - acc, FRAME);
            check("vec_start", {31'd0, last_raw[0]}, 32'd0);
            check("vec_stop", {31'd0, last_raw[NB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
            check("vec_parity", {31'd0, last_raw[9]}, {31'd0, vecs[i].par});
`endif
            drain_sb();
        end

        // Back-to-back through the buffer model, CR appended after LF
        b2b = '{8'h41, 8'h42, 8'h0A};
        if (b2b[b2b.size()-1] == 8'h0A) b2b.push_back(8'h0D);
        repeat (5) @(negedge clk);
        start_q.delete();
        done_cq.delete();
        base = done_cnt;
        foreach (b2b[i]) send_byte(b2b[i], acc);
        for (int n = 0; n < 2 * FRAME && done_cnt < base + 4; n++) @(negedge clk);
        check("b2b_done_cnt", done_cnt - base, 4);
        check("b2b_frames", start_q.size(), 4);
        for (int i = 0; i + 1 < start_q.size() && i < done_cq.size(); i++) begin
            gap = start_q[i+1] - done_cq[i];
            check("b2b_gap_le2", {31'd0, (gap <= 2 && gap > 0)}, 32'd1);
        end
        drain_sb();

        // send mid-frame is dropped
        f0 = frames;
        send_byte(8'h00, acc);
        repeat (30) @(negedge clk);
        u_if.send = 1'b1;
        u_if.data = 8'hFF;
        @(negedge clk);
        u_if.send = 1'b0;
        wait_done(dc);
        check("ign_done_lat", dc - acc, FRAME);
        repeat (3 * FRAME) @(negedge clk);
        check("ign_one_frame", frames - f0, 1);
        drain_sb();

        // Reset during data bit 3 aborts the frame, then a clean frame follows
        send_byte(8'h00, acc);
        while (cyc < acc + 4 * C + 4) @(negedge clk);
        check("mid_tx_low", {31'd0, tx}, 32'd0);
        base = done_cnt;
        f0 = frames;
        rst_n = 1'b0;
        #1 check("mid_rst_tx", {31'd0, tx}, 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5 * C) @(negedge clk);
        check("mid_no_done", done_cnt - base, 0);
        check("mid_no_frame", frames - f0, 0);
        check("mid_ready", {31'd0, u_if.ready}, 32'd1);
        send_byte(8'hA5, acc);
        wait_done(dc);
        check("mid_after_lat", dc - acc, FRAME);
        check("mid_after_data", {24'd0, last_raw[8:1]}, 32'hA5);
        drain_sb();

`ifdef UART_TX_PARITY_EN
        send_byte(8'h07, acc);
        wait_done(dc);
        check("par07_bit", {31'd0, last_raw[9]}, 32'd1);
        check("par07_len", dc - acc, 110);
        send_byte(8'h03, acc);
        wait_done(dc);
        check("par03_bit", {31'd0, last_raw[9]}, 32'd0);
        check("par03_len", dc - acc, 110);
        drain_sb();
`endif

        repeat (2 * FRAME) @(negedge clk);
        drain_sb();
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
